// File: rtl/platformniossdram_mem_pkg.sv
// Shared types for the on-chip RAM arbiter: default widths, master IDs and
// the per-master command bundle.
package platformniossdram_mem_pkg;

  localparam int MEM_ADDR_W = 15;
  localparam int MEM_DATA_W = 32;
  localparam int MEM_BE_W   = MEM_DATA_W / 8;

  typedef enum logic {
    M0 = 1'b0,
    M1 = 1'b1
  } master_id_e;

  typedef struct packed {
    logic [MEM_ADDR_W-1:0] address;
    logic [MEM_BE_W-1:0]   byteenable;
    logic                  read;
    logic                  write;
    logic [MEM_DATA_W-1:0] writedata;
  } mem_cmd_t;

endpackage

// File: rtl/platformniossdram_rr_hold_arbiter.sv
// Two-way round-robin arbiter: the current owner keeps the RAM for up to
// HOLD_MAX consecutive contended grants, then the other master gets a turn.
module platformniossdram_rr_hold_arbiter
  import platformniossdram_mem_pkg::*;
#(
  parameter int HOLD_MAX = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  localparam int               CNT_W    = $clog2(HOLD_MAX + 1);
  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_MAX);

  master_id_e       owner_q, owner_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic [1:0]       req;
  logic [1:0]       gnt;
  logic             keep_owner;
  logic             pick_m1;
  master_id_e       gnt_id;

  // No grants while reset is held, so the datapath stays quiet.
  assign req    = reset_n ? req_i : 2'b00;
  assign gnt_id = master_id_e'(gnt[1]);

  // Owner resets to m0 so m0 takes the first contended grant.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      owner_q <= M0;
      hold_q  <= '0;
    end else begin
      owner_q <= owner_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    owner_d = owner_q;
    hold_d  = hold_q;
    if (gnt == 2'b00) begin
      hold_d = '0;
    end else if (gnt_id == owner_q) begin
      if (hold_q != HOLD_LIM) hold_d = hold_q + 1'b1;
    end else begin
      owner_d = gnt_id;
      hold_d  = CNT_W'(1);
    end
  end

  always_comb begin
    keep_owner = hold_q < HOLD_LIM;
    pick_m1    = keep_owner ? (owner_q == M1) : (owner_q == M0);
    gnt        = req;
    if (req == 2'b11) gnt = pick_m1 ? 2'b10 : 2'b01;
  end

  assign gnt_o = gnt;

endmodule

// File: rtl/platformniossdram_onchip_memory_arbiter.sv
// Shares the single-port on-chip RAM between the Nios data master (m0) and the
// CORDIC/DMA master (m1); steers the fixed 1-cycle read return to its issuer.
module platformniossdram_onchip_memory_arbiter
  import platformniossdram_mem_pkg::*;
#(
  parameter int ADDR_W   = MEM_ADDR_W,
  parameter int DATA_W   = MEM_DATA_W,
  parameter int HOLD_MAX = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_W-1:0]     m0_address,
  input  logic [DATA_W/8-1:0]   m0_byteenable,
  input  logic                  m0_read,
  input  logic                  m0_write,
  input  logic [DATA_W-1:0]     m0_writedata,
  output logic                  m0_waitrequest,
  output logic [DATA_W-1:0]     m0_readdata,
  output logic                  m0_readdatavalid,
  input  logic [ADDR_W-1:0]     m1_address,
  input  logic [DATA_W/8-1:0]   m1_byteenable,
  input  logic                  m1_read,
  input  logic                  m1_write,
  input  logic [DATA_W-1:0]     m1_writedata,
  output logic                  m1_waitrequest,
  output logic [DATA_W-1:0]     m1_readdata,
  output logic                  m1_readdatavalid,
  output logic [ADDR_W-1:0]     mem_address,
  output logic [DATA_W/8-1:0]   mem_byteenable,
  output logic                  mem_chipselect,
  output logic                  mem_write,
  output logic [DATA_W-1:0]     mem_writedata,
  input  logic [DATA_W-1:0]     mem_readdata
);

  if (ADDR_W != MEM_ADDR_W || DATA_W != MEM_DATA_W) begin : g_cfg_check
    $error("ADDR_W/DATA_W must match the widths of mem_cmd_t");
  end

  mem_cmd_t   cmd0, cmd1, cmd_sel;
  logic [1:0] req, gnt;
  logic       rdv_vld_p1_q, rdv_vld_p1_d;
  master_id_e rdv_id_p1_q, rdv_id_p1_d;

  assign cmd0 = '{address: m0_address, byteenable: m0_byteenable, read: m0_read,
                  write: m0_write, writedata: m0_writedata};
  assign cmd1 = '{address: m1_address, byteenable: m1_byteenable, read: m1_read,
                  write: m1_write, writedata: m1_writedata};

  assign req = {cmd1.read | cmd1.write, cmd0.read | cmd0.write};

  platformniossdram_rr_hold_arbiter #(
    .HOLD_MAX (HOLD_MAX)
  ) u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req_i   (req),
    .gnt_o   (gnt)
  );

  // Command stage: the granted master drives the RAM directly.
  assign cmd_sel        = gnt[1] ? cmd1 : cmd0;
  assign mem_chipselect = |gnt;
  assign mem_write      = mem_chipselect & cmd_sel.write;
  assign mem_address    = cmd_sel.address;
  assign mem_byteenable = cmd_sel.byteenable;
  assign mem_writedata  = cmd_sel.writedata;

  assign m0_waitrequest = ~reset_n | (req[0] & ~gnt[0]);
  assign m1_waitrequest = ~reset_n | (req[1] & ~gnt[1]);

  // A read+write collision is treated as a write, so no return is tracked.
  assign rdv_vld_p1_d = mem_chipselect & cmd_sel.read & ~cmd_sel.write;
  assign rdv_id_p1_d  = master_id_e'(gnt[1]);

  // Return stage: the RAM output is valid one cycle after the accepted read.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdv_vld_p1_q <= 1'b0;
      rdv_id_p1_q  <= M0;
    end else begin
      rdv_vld_p1_q <= rdv_vld_p1_d;
      rdv_id_p1_q  <= rdv_id_p1_d;
    end
  end

  assign m0_readdatavalid = reset_n & rdv_vld_p1_q & (rdv_id_p1_q == M0);
  assign m1_readdatavalid = reset_n & rdv_vld_p1_q & (rdv_id_p1_q == M1);
  assign m0_readdata      = mem_readdata;
  assign m1_readdata      = mem_readdata;

  a_m0_rw_excl : assert property (@(posedge clk) disable iff (!reset_n) !(m0_read && m0_write))
    else $error("m0 asserted read and write in the same cycle");
  a_m1_rw_excl : assert property (@(posedge clk) disable iff (!reset_n) !(m1_read && m1_write))
    else $error("m1 asserted read and write in the same cycle");

endmodule

// File: tb/tb_platformniossdram_onchip_memory_arbiter.sv
// Scoreboard bench for the two-master RAM arbiter (HOLD_MAX=4 main instance,
// HOLD_MAX=1 instance sharing the master inputs for the alternation case).
module tb_platformniossdram_onchip_memory_arbiter;

  localparam int AW = 15;
  localparam int DW = 32;
  localparam int BW = DW / 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n;
  logic [AW-1:0] m0_address, m1_address;
  logic [BW-1:0] m0_byteenable, m1_byteenable;
  logic          m0_read, m0_write, m1_read, m1_write;
  logic [DW-1:0] m0_writedata, m1_writedata;
  logic          m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
  logic [DW-1:0] m0_readdata, m1_readdata;
  logic [AW-1:0] mem_address;
  logic [BW-1:0] mem_byteenable;
  logic          mem_chipselect, mem_write;
  logic [DW-1:0] mem_writedata, mem_readdata;

  logic          h1_m0_wr, h1_m1_wr, h1_m0_rdv, h1_m1_rdv;
  logic [DW-1:0] h1_m0_rd, h1_m1_rd, h1_mem_wd;
  logic [AW-1:0] h1_mem_addr;
  logic [BW-1:0] h1_mem_be;
  logic          h1_mem_cs, h1_mem_we;
  logic [DW-1:0] h1_mem_rd = '0;

  platformniossdram_onchip_memory_arbiter #(.ADDR_W(AW), .DATA_W(DW), .HOLD_MAX(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable), .mem_chipselect(mem_chipselect),
    .mem_write(mem_write), .mem_writedata(mem_writedata), .mem_readdata(mem_readdata)
  );

  platformniossdram_onchip_memory_arbiter #(.ADDR_W(AW), .DATA_W(DW), .HOLD_MAX(1)) dut_h1 (
    .clk(clk), .reset_n(reset_n),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(h1_m0_wr),
    .m0_readdata(h1_m0_rd), .m0_readdatavalid(h1_m0_rdv),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(h1_m1_wr),
    .m1_readdata(h1_m1_rd), .m1_readdatavalid(h1_m1_rdv),
    .mem_address(h1_mem_addr), .mem_byteenable(h1_mem_be), .mem_chipselect(h1_mem_cs),
    .mem_write(h1_mem_we), .mem_writedata(h1_mem_wd), .mem_readdata(h1_mem_rd)
  );

  function automatic logic [DW-1:0] pre(input logic [AW-1:0] a);
    return 32'h5A00_0000 | {17'h0, a};
  endfunction

  // RAM model: address registered on a selected cycle, output unregistered.
  logic [DW-1:0] ram [0:(1<<AW)-1];
  logic [AW-1:0] ram_addr_q;
  assign mem_readdata = ram[ram_addr_q];

  initial begin
    for (int i = 0; i < (1 << AW); i++) ram[i] = pre(AW'(i));
    ram[15'h0010] = 32'hDEADBEEF;
    ram[15'h7FFF] = 32'hAAAAAAAA;
    ram[15'h0005] = 32'h05050505;
    ram[15'h0000] = 32'h0BADF00D;
    ram_addr_q = '0;
    forever begin
      @(posedge clk);
      if (mem_chipselect) begin
        if (mem_write)
          for (int b = 0; b < BW; b++)
            if (mem_byteenable[b]) ram[mem_address][8*b +: 8] = mem_writedata[8*b +: 8];
        ram_addr_q = mem_address;
      end
    end
  end

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int prev_g1 = -1;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  typedef struct {
    logic [1:0]    vec;
    logic [DW-1:0] data;
    int            due;
  } exp_t;
  exp_t q[$];

  // Monitor: each expected return must appear in exactly its due cycle.
  always @(negedge clk) begin : mon
    logic [1:0] v;
    exp_t       e;
    v = {m1_readdatavalid, m0_readdatavalid};
    if (q.size() > 0 && q[0].due <= cyc) begin
      e = q.pop_front();
      check("rdv_vec", {30'b0, v}, {30'b0, e.vec});
      check("rdata", v[1] ? m1_readdata : m0_readdata, e.data);
    end else if (v != 2'b00) begin
      check("rdv_unexpected", {30'b0, v}, 32'h0);
    end
  end

  // g: expected main grant (0=m0, 1=m1, 2=none); g1: expected HOLD_MAX=1 grant or -1.
  task automatic step(input int g, input bit push, input logic [DW-1:0] ed, input int g1);
    logic r0, r1;
    exp_t e;
    r0 = m0_read | m0_write;
    r1 = m1_read | m1_write;
    if (push) begin
      e.vec  = (g == 1) ? 2'b10 : 2'b01;
      e.data = ed;
      e.due  = cyc + 1;
      q.push_back(e);
    end
    @(negedge clk);
    check("m0_waitreq", m0_waitrequest, r0 && g != 0);
    check("m1_waitreq", m1_waitrequest, r1 && g != 1);
    check("mem_cs", mem_chipselect, g != 2);
    if (g != 2) begin
      check("mem_addr", mem_address, (g == 1) ? m1_address : m0_address);
      check("mem_wr", mem_write, (g == 1) ? m1_write : m0_write);
    end
    if (prev_g1 >= 0)
      check("h1_rdv", {30'b0, h1_m1_rdv, h1_m0_rdv},
            (prev_g1 == 0) ? 32'd1 : (prev_g1 == 1) ? 32'd2 : 32'd0);
    if (g1 >= 0) begin
      check("h1_m0_waitreq", h1_m0_wr, g1 == 1);
      check("h1_m1_waitreq", h1_m1_wr, g1 == 0);
    end
    prev_g1 = g1;
    @(posedge clk);
    #1;
  endtask

  task automatic reset_checks();
    check("rst_m0_waitreq", m0_waitrequest, 1);
    check("rst_m1_waitreq", m1_waitrequest, 1);
    check("rst_rdv", {30'b0, m1_readdatavalid, m0_readdatavalid}, 0);
    check("rst_mem_cs", mem_chipselect, 0);
    check("rst_mem_wr", mem_write, 0);
    check("rst_h1_waitreq", {30'b0, h1_m1_wr, h1_m0_wr}, 3);
  endtask

  // Both masters read continuously; each advances its address once accepted.
  task automatic run_both(input int n, input int base0, input int base1, input bit chk_h1);
    int i0, i1, g;
    i0 = 0;
    i1 = 0;
    m0_read = 1'b1;
    m1_read = 1'b1;
    for (int k = 0; k < n; k++) begin
      g = (k / 4) % 2;
      m0_address = AW'(base0 + i0);
      m1_address = AW'(base1 + i1);
      step(g, 1'b1, pre((g == 1) ? m1_address : m0_address), chk_h1 ? (k % 2) : -1);
      if (g == 0) i0++;
      else i1++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0;
    m0_address = '0; m1_address = '0;
    m0_byteenable = 4'hF; m1_byteenable = 4'hF;
    m0_read = 1'b0; m0_write = 1'b0; m1_read = 1'b0; m1_write = 1'b0;
    m0_writedata = '0; m1_writedata = '0;
    repeat (2) @(posedge clk);
    #1;
    m0_write = 1'b1;
    m1_read  = 1'b1;
    @(negedge clk);
    reset_checks();
    @(posedge clk);
    #1;
    m0_write = 1'b0;
    m1_read  = 1'b0;
    reset_n  = 1'b1;

    // Single read after reset.
    m0_read = 1'b1; m0_address = 15'h0010;
    step(0, 1'b1, 32'hDEADBEEF, -1);
    m0_read = 1'b0;
    step(2, 1'b0, '0, -1);

    // Byte-lane write at the top address, read back, then address 0 untouched.
    m1_write = 1'b1; m1_address = 15'h7FFF; m1_writedata = 32'h11223344; m1_byteenable = 4'h3;
    step(1, 1'b0, '0, -1);
    m1_write = 1'b0; m1_read = 1'b1; m1_byteenable = 4'hF;
    step(1, 1'b1, 32'hAAAA3344, -1);
    m1_address = 15'h0000;
    step(1, 1'b1, 32'h0BADF00D, -1);
    m1_read = 1'b0;
    step(2, 1'b0, '0, -1);

    // Read / write / read on the same word.
    m0_read = 1'b1; m0_address = 15'h0005;
    step(0, 1'b1, 32'h05050505, -1);
    m0_read = 1'b0; m1_write = 1'b1; m1_address = 15'h0005; m1_writedata = 32'hCAFEF00D;
    step(1, 1'b0, '0, -1);
    m1_write = 1'b0; m0_read = 1'b1;
    step(0, 1'b1, 32'hCAFEF00D, -1);
    m0_read = 1'b0;
    step(2, 1'b0, '0, -1);

    // m0 alone for 10 cycles, one idle cycle, then contention: m0 x4 before m1.
    m0_read = 1'b1;
    for (int i = 0; i < 10; i++) begin
      m0_address = AW'(32'h300 + i);
      step(0, 1'b1, pre(m0_address), -1);
    end
    m0_read = 1'b0;
    step(2, 1'b0, '0, -1);
    run_both(6, 32'h310, 32'h320, 1'b0);
    m0_read = 1'b0; m1_read = 1'b0;
    step(2, 1'b0, '0, -1);

    // Reset mid-read: the accepted read must never return.
    m0_read = 1'b1; m0_address = 15'h0010;
    step(0, 1'b0, '0, -1);
    m0_read = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check("rdv_after_reset_edge", {30'b0, m1_readdatavalid, m0_readdatavalid}, 0);
    m0_read = 1'b1; m1_read = 1'b1;
    @(negedge clk);
    reset_checks();
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Contention from the first cycle after reset on both instances.
    prev_g1 = 2;
    run_both(16, 32'h100, 32'h200, 1'b1);
    m0_read = 1'b0; m1_read = 1'b0;
    step(2, 1'b0, '0, -1);
    step(2, 1'b0, '0, -1);

    check("queue_drain", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
